// File: rtl/bulls_cows_engine_if.sv
`default_nettype none
// ============================================================================
// bulls_cows_engine_if : key/switch inputs and display/score outputs of the
//                        Bulls-and-Cows game engine
// Revision 1.0
// ============================================================================
interface bulls_cows_engine_if #(
  parameter int N_DIGITS  = 4,
  parameter int MAX_TRIES = 5
);
  localparam int SW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic                  confirm_pulse;
  logic                  back_pulse;
  logic                  hist_pulse;
  logic [3:0]            digit_in;
  logic                  digit_valid;
  logic [3:0]            rand_digit;
  logic [4*N_DIGITS-1:0] disp_char;
  logic [2:0]            phase;
  logic [SW-1:0]         res_a;
  logic [SW-1:0]         res_b;
  logic [TW-1:0]         tries_left;
  logic                  score_valid;
  logic                  blink;

  modport master (
    output confirm_pulse, back_pulse, hist_pulse, digit_in, digit_valid, rand_digit,
    input  disp_char, phase, res_a, res_b, tries_left, score_valid, blink
  );

  modport slave (
    input  confirm_pulse, back_pulse, hist_pulse, digit_in, digit_valid, rand_digit,
    output disp_char, phase, res_a, res_b, tries_left, score_valid, blink
  );
endinterface
`default_nettype wire

// File: rtl/bulls_cows_engine.sv
`default_nettype none
// ============================================================================
// bulls_cows_engine : N-digit Bulls-and-Cows engine with sequential scoring
//                     and a browsable guess history
// Revision 1.0
// ============================================================================
module bulls_cows_engine #(
  parameter int N_DIGITS  = 4,
  parameter int MAX_TRIES = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  bulls_cows_engine_if.slave        bus
);
  localparam int PW = $clog2(N_DIGITS);
  localparam int SW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int HD = 1 << TW;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW = 4 * N_DIGITS;

  localparam logic [PW-1:0] LAST_POS   = PW'(N_DIGITS - 1);
  localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
  localparam logic [3:0]    C_UNDER    = 4'hC;
  localparam logic [3:0]    C_BLANK    = 4'hF;
  // Patterns are built 8 digits wide and cut down to the configured length
  localparam logic [31:0]   IDLE_FULL  = {16'hFFFF, 16'h1A2B};
  localparam logic [31:0]   WIN_FULL   = {4'(N_DIGITS), 4'hA, 4'h0, 4'hB, 16'hFFFF};
  localparam logic [DW-1:0] IDLE_DISP  = IDLE_FULL[DW-1:0];
  localparam logic [DW-1:0] WIN_DISP   = WIN_FULL[31 -: DW];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    GUESS  = 3'd2,
    SCORE  = 3'd3,
    RESULT = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } state_t;

  state_t        state;
  logic [3:0]    target [N_DIGITS];
  logic [3:0]    guess  [N_DIGITS];
  logic [3:0]    hist_g [HD][N_DIGITS];
  logic [SW-1:0] hist_a [HD];
  logic [SW-1:0] hist_b [HD];
  logic [PW-1:0] pos;
  logic [PW-1:0] idx;
  logic [SW-1:0] acc_a;
  logic [SW-1:0] acc_b;
  logic [TW-1:0] wptr;
  logic [TW-1:0] view;
  logic [TW-1:0] tries;
  logic          score_valid_r;
  logic          blink_r;
  logic [BW-1:0] blink_cnt;

  logic [3:0]    cand;
  logic          has_cand;
  logic          dup;
  logic          cand_ok;
  logic          hit;
  logic [SW-1:0] cows;
  logic [SW-1:0] sum_a;
  logic [SW-1:0] sum_b;
  logic [TW-1:0] older;
  logic [DW-1:0] disp;

  always_comb begin
    cand     = bus.digit_in;
    has_cand = bus.digit_valid;
    if (state == SET && !bus.digit_valid) begin
      cand     = bus.rand_digit;
      has_cand = 1'b1;
    end
    dup = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (PW'(k) > pos && ((state == SET) ? target[k] : guess[k]) == cand) dup = 1'b1;
    end
    cand_ok = has_cand && (cand <= 4'd9) && !dup;
  end

  // A position is either a bull or contributes its cow matches, never both
  always_comb begin
    hit  = (guess[idx] == target[idx]);
    cows = '0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((PW'(j) != idx) && (guess[idx] == target[j])) cows = cows + SW'(1);
    end
    sum_a = acc_a + (hit ? SW'(1) : SW'(0));
    sum_b = acc_b + (hit ? SW'(0) : cows);
    older = (view == '0) ? (wptr - TW'(1)) : (view - TW'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pos           <= '0;
      idx           <= '0;
      acc_a         <= '0;
      acc_b         <= '0;
      wptr          <= '0;
      view          <= '0;
      tries         <= TRIES_INIT;
      score_valid_r <= 1'b0;
      blink_r       <= 1'b0;
      blink_cnt     <= '0;
      for (int k = 0; k < N_DIGITS; k++) begin
        target[k] <= '0;
        guess[k]  <= '0;
      end
      for (int h = 0; h < HD; h++) begin
        hist_a[h] <= '0;
        hist_b[h] <= '0;
        for (int k = 0; k < N_DIGITS; k++) hist_g[h][k] <= '0;
      end
    end else begin
      score_valid_r <= 1'b0;
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_r   <= ~blink_r;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      case (state)
        IDLE: begin
          tries <= TRIES_INIT;
          if (bus.confirm_pulse) begin
            state <= SET;
            pos   <= LAST_POS;
          end
        end
        SET, GUESS: begin
          if (bus.confirm_pulse) begin
            if (cand_ok) begin
              if (state == SET) target[pos] <= cand;
              else              guess[pos]  <= cand;
              if (pos != '0) begin
                pos <= pos - PW'(1);
              end else if (state == SET) begin
                state <= GUESS;
                pos   <= LAST_POS;
              end else begin
                state <= SCORE;
                idx   <= '0;
                acc_a <= '0;
                acc_b <= '0;
              end
            end
          end else if (bus.back_pulse && pos != LAST_POS) begin
            pos <= pos + PW'(1);
          end
        end
        SCORE: begin
          if (idx == LAST_POS) begin
            for (int k = 0; k < N_DIGITS; k++) hist_g[wptr][k] <= guess[k];
            hist_a[wptr]  <= sum_a;
            hist_b[wptr]  <= sum_b;
            view          <= wptr;
            wptr          <= wptr + TW'(1);
            tries         <= tries - TW'(1);
            score_valid_r <= 1'b1;
            if (sum_a == SW'(N_DIGITS))  state <= WIN;
            else if (tries == TW'(1))    state <= LOSE;
            else                         state <= RESULT;
          end else begin
            idx   <= idx + PW'(1);
            acc_a <= sum_a;
            acc_b <= sum_b;
          end
        end
        RESULT: begin
          if (bus.confirm_pulse) begin
            state <= GUESS;
            pos   <= LAST_POS;
            view  <= '0;
          end else if (bus.hist_pulse) begin
            view <= older;
          end
        end
        WIN, LOSE: begin
          if (bus.hist_pulse) view <= older;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    disp = '1;
    case (state)
      IDLE: disp = IDLE_DISP;
      WIN:  disp = WIN_DISP;
      default: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (state == SCORE)        disp[4*i +: 4] = guess[i];
          else if (state == RESULT)  disp[4*i +: 4] = hist_g[view][i];
          else if (state == LOSE)    disp[4*i +: 4] = target[i];
          else if (PW'(i) > pos)     disp[4*i +: 4] = (state == SET) ? target[i] : guess[i];
          else if (PW'(i) == pos)    disp[4*i +: 4] = blink_r ? (has_cand ? cand : C_UNDER) : C_BLANK;
          else                       disp[4*i +: 4] = C_UNDER;
        end
      end
    endcase
  end

  assign bus.disp_char   = disp;
  assign bus.phase       = state;
  assign bus.res_a       = hist_a[view];
  assign bus.res_b       = hist_b[view];
  assign bus.tries_left  = tries;
  assign bus.score_valid = score_valid_r;
  assign bus.blink       = blink_r;
endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_engine.sv
`default_nettype none
// ============================================================================
// tb_bulls_cows_engine : scoreboard/table bench for two engine configurations
// Revision 1.0
// ============================================================================
module tb_bulls_cows_engine;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       confirm, back, hist;
  logic [3:0] digit_in, rand_digit;
  logic       digit_valid;

  always #5 clk = ~clk;

  bulls_cows_engine_if #(.N_DIGITS(N), .MAX_TRIES(5)) b5 ();
  bulls_cows_engine_if #(.N_DIGITS(N), .MAX_TRIES(2)) b2 ();

  assign b5.confirm_pulse = confirm;
  assign b5.back_pulse    = back;
  assign b5.hist_pulse    = hist;
  assign b5.digit_in      = digit_in;
  assign b5.digit_valid   = digit_valid;
  assign b5.rand_digit    = rand_digit;
  assign b2.confirm_pulse = confirm;
  assign b2.back_pulse    = back;
  assign b2.hist_pulse    = hist;
  assign b2.digit_in      = digit_in;
  assign b2.digit_valid   = digit_valid;
  assign b2.rand_digit    = rand_digit;

  bulls_cows_engine #(.N_DIGITS(N), .MAX_TRIES(5), .BLINK_DIV(3)) dut5 (
    .clk(clk), .reset_n(reset_n), .bus(b5.slave));
  bulls_cows_engine #(.N_DIGITS(N), .MAX_TRIES(2), .BLINK_DIV(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave));

  typedef struct {int a; int b; int tries; int ph; int cyc;} sb_t;
  typedef struct {logic [15:0] g; int a; int b; int tries; int ph;} vec_t;

  sb_t  sb[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  sb_t  none  = '{a: 0, b: 0, tries: 0, ph: 0, cyc: 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoring results are retired here as score_valid pulses
  always @(negedge clk) begin
    if (b5.score_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_score_valid", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("score_latency", cyc, e.cyc);
        chk("score_res_a", b5.res_a, e.a);
        chk("score_res_b", b5.res_b, e.b);
        chk("score_tries", b5.tries_left, e.tries);
        chk("score_phase", b5.phase, e.ph);
      end
    end
  end

  task automatic step(input bit c, input bit bk, input bit h, input bit push, input sb_t item);
    @(negedge clk);
    if (push) begin
      item.cyc = cyc + N + 1;
      sb.push_back(item);
    end
    confirm = c; back = bk; hist = h;
    @(negedge clk);
    confirm = 1'b0; back = 1'b0; hist = 1'b0;
  endtask

  task automatic enter(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    step(1, 0, 0, 0, none);
  endtask

  task automatic wait_scored();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_phase"}, b5.phase, 0);
    chk({tag, "_disp"}, b5.disp_char, 16'h1A2B);
    chk({tag, "_tries"}, b5.tries_left, 5);
    chk({tag, "_res_a"}, b5.res_a, 0);
    chk({tag, "_res_b"}, b5.res_b, 0);
    chk({tag, "_sv"}, b5.score_valid, 0);
    chk({tag, "_blink"}, b5.blink, 0);
    chk({tag, "_tries2"}, b2.tries_left, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] hg[3];
    int          ha[3], hb[3];
    logic [3:0]  rseq[5];
    sb_t         it;

    vecs[0] = '{g: 16'h1325, a: 1, b: 2, tries: 4, ph: 4};
    vecs[1] = '{g: 16'h5678, a: 0, b: 0, tries: 3, ph: 4};
    vecs[2] = '{g: 16'h4321, a: 0, b: 4, tries: 2, ph: 4};
    vecs[3] = '{g: 16'h1243, a: 2, b: 2, tries: 1, ph: 4};
    vecs[4] = '{g: 16'h2143, a: 0, b: 4, tries: 0, ph: 6};
    hg = '{16'h5678, 16'h1325, 16'h4321};
    ha = '{0, 1, 0};
    hb = '{0, 2, 4};
    rseq = '{4'd3, 4'd3, 4'd7, 4'd1, 4'd5};

    confirm = 0; back = 0; hist = 0; digit_in = 0; digit_valid = 0; rand_digit = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("blink_on", b5.blink, 1);

    // Game 1: random target 3715, navigation corners, then a win
    step(1, 0, 0, 0, none);
    chk("idle_to_set", b5.phase, 1);
    digit_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_digit = rseq[k];
      step(1, 0, 0, 0, none);
    end
    chk("set_entered", b5.disp_char[15:8], 8'h37);
    rand_digit = rseq[3];
    step(1, 0, 0, 0, none);
    chk("set_dup_rejected", b5.phase, 1);
    rand_digit = rseq[4];
    step(1, 0, 0, 0, none);
    chk("set_to_guess", b5.phase, 2);

    digit_valid = 1'b1; digit_in = 4'd3;
    step(0, 1, 0, 0, none);
    chk("back_top_ignored", b5.disp_char[11:0], 12'hCCC);
    digit_in = 4'd12;
    step(1, 0, 0, 0, none);
    chk("digit12_rejected", b5.disp_char[11:0], 12'hCCC);
    digit_in = 4'd3;
    step(1, 1, 0, 0, none);
    chk("confirm_beats_back", b5.disp_char[15:12], 4'h3);
    chk("confirm_beats_back_pend", b5.disp_char[7:0], 8'hCC);
    step(0, 1, 0, 0, none);
    chk("back_step", b5.disp_char[11:8], 4'hC);
    enter(4'd3);
    enter(4'd7);
    enter(4'd7);
    chk("guess_dup_rejected", b5.disp_char[3:0], 4'hC);
    enter(4'd1);
    chk("guess_pending", b5.phase, 2);
    digit_in = 4'd5;
    it = '{a: 4, b: 0, tries: 4, ph: 5, cyc: 0};
    step(1, 0, 0, 1, it);
    wait_scored();
    chk("win_disp", b5.disp_char, 16'h4A0B);
    chk("win_phase2", b2.phase, 5);
    chk("win_tries2", b2.tries_left, 1);
    step(1, 0, 0, 0, none);
    chk("win_hold_phase", b5.phase, 5);
    chk("win_hold_tries", b5.tries_left, 4);
    chk("win_hold_disp", b5.disp_char, 16'h4A0B);
    step(0, 0, 1, 0, none);
    chk("win_hist_a", b5.res_a, 4);
    chk("win_hist_b", b5.res_b, 0);

    // Game 2: target 1234, table of rounds, history browse, loss
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset2_phase", b5.phase, 0);
    reset_n = 1'b1;
    step(1, 0, 0, 0, none);
    enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4);
    chk("set2_done", b5.phase, 2);
    for (int r = 0; r < 5; r++) begin
      for (int k = 3; k >= 1; k--) enter(vecs[r].g[4*k +: 4]);
      digit_in = vecs[r].g[3:0];
      it = '{a: vecs[r].a, b: vecs[r].b, tries: vecs[r].tries, ph: vecs[r].ph, cyc: 0};
      step(1, 0, 0, 1, it);
      wait_scored();
      chk($sformatf("round%0d_disp", r), b5.disp_char,
          (vecs[r].ph == 6) ? 16'h1234 : vecs[r].g);
      if (r == 0) begin
        chk("t2_round0_tries", b2.tries_left, 1);
        chk("t2_round0_phase", b2.phase, 4);
      end
      if (r == 1) begin
        chk("t2_lose_phase", b2.phase, 6);
        chk("t2_lose_tries", b2.tries_left, 0);
        chk("t2_lose_disp", b2.disp_char, 16'h1234);
      end
      if (r == 2) begin
        for (int p = 0; p < 3; p++) begin
          step(0, 0, 1, 0, none);
          chk($sformatf("hist%0d_disp", p), b5.disp_char, hg[p]);
          chk($sformatf("hist%0d_a", p), b5.res_a, ha[p]);
          chk($sformatf("hist%0d_b", p), b5.res_b, hb[p]);
        end
      end
      if (vecs[r].ph == 4) begin
        step(1, 0, 0, 0, none);
        chk($sformatf("round%0d_next", r), b5.phase, 2);
      end
    end
    chk("t2_final_phase", b2.phase, 6);
    chk("t2_final_disp", b2.disp_char, 16'h1234);

    // Game 3: reset while scoring is in flight
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, none);
    enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4);
    enter(4'd5); enter(4'd6); enter(4'd7);
    digit_in = 4'd8;
    step(1, 0, 0, 0, none);
    chk("in_score", b5.phase, 3);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("mid_score_reset");
    repeat (N + 3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bulls_cows_engine.md
# bulls_cows_engine

Parametrised Bulls-and-Cows (nA mB) game engine for the DE1-SoC game top. It takes debounced key pulses, an encoded switch digit and a random digit, and produces per-digit display codes, A/B scores and a tries-remaining count. It generalises the fixed 4-digit / 5-try game to N_DIGITS and MAX_TRIES. It adds a sequential scoring pass and a guess-history buffer that can be recalled between rounds.

## Interface
- N_DIGITS, 4: secret/guess length, legal 4..8; digit radix fixed at 10.
- MAX_TRIES, 5: guesses allowed, legal 1..15; also the history depth.
- BLINK_DIV, 25000000: clk cycles per blink half-period.
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- confirm_pulse  in  1  one-cycle debounced confirm (KEY0).
- back_pulse  in  1  one-cycle debounced back (KEY1).
- hist_pulse  in  1  one-cycle history-step request.
- digit_in  in  4  encoded switch value.
- digit_valid  in  1  a switch is active.
- rand_digit  in  4  LFSR digit.
- disp_char  out  4*N_DIGITS  display codes; slice [4i+3:4i] is position i; position N_DIGITS-1 is leftmost. Codes: 0-9 digit, 0xA 'A', 0xB 'b', 0xC '_', 0xF blank.
- phase  out  3  0 IDLE, 1 SET, 2 GUESS, 3 SCORE, 4 RESULT, 5 WIN, 6 LOSE.
- res_a, res_b  out  $clog2(N_DIGITS+1)  score of the displayed history entry.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining guesses.
- score_valid  out  1  one-cycle pulse when scoring completes.
- blink  out  1  blink phase, 1 = on.

## Operation
- Registers: target[N], guess[N], pos counter, scoring index, A/B accumulators, history of MAX_TRIES entries (guess digits + A + B), write pointer, view pointer.
- Candidate value:
  - SET: digit_in if digit_valid, else rand_digit.
  - GUESS: digit_in, and only when digit_valid is 1.
  - A candidate greater than 9 is rejected.
- IDLE: confirm -> SET with pos = N_DIGITS-1. tries_left is held at MAX_TRIES.
- SET/GUESS: confirm with a legal, non-duplicate candidate writes target[pos] or guess[pos].
  - Duplicate means equal to an already-entered position above pos.
  - If pos > 0, pos decrements. If pos = 0, SET -> GUESS (pos = N-1) and GUESS -> SCORE.
  - back with pos < N-1 increments pos. back at pos = N-1 is ignored.
  - confirm and back in the same cycle: confirm wins; back is dropped even if confirm is rejected.
- SCORE: one position per cycle, i = 0..N-1.
  - A += (guess[i] == target[i]).
  - Otherwise B += count of j != i with guess[i] == target[j].
  - After N cycles: history[wptr] <= guess and score, wptr++, tries_left--, score_valid pulses.
  - Next state: A == N -> WIN; else tries_left reaching 0 -> LOSE; else RESULT.
- RESULT:
  - view = newest entry. Display shows the viewed guess; res_a/res_b show its score.
  - hist_pulse moves view to the next-older entry; from the oldest it wraps to the newest.
  - confirm -> GUESS with pos = N-1, view reset.
- WIN and LOSE are terminal until reset. hist_pulse still browses history in both.
- Display:
  - Entered positions show their digit.
  - The active position shows the candidate (or '_' when no candidate) while blink = 1, and blank while blink = 0.
  - Pending positions show '_'.
  - IDLE: rightmost four positions show 1, A, 2, b; others blank.
  - WIN: leftmost four show N_DIGITS, A, 0, b; others blank.
  - LOSE: shows target.

## Timing
- Reset (asynchronous, immediate, also mid-SCORE):
  - phase = 0, res_a = res_b = 0, tries_left = MAX_TRIES, score_valid = 0, blink = 0.
  - target, guess and history cleared to 0; pointers = 0; disp_char = IDLE pattern.
- State and register updates take effect on the clk edge that samples the pulse. disp_char/phase update in the same cycle (disp_char is combinational from registers).
- Confirm at GUESS pos 0 in cycle t:
  - SCORE occupies cycles t+1..t+N.
  - score_valid is high in cycle t+N+1, and tries_left, history and phase update at that same edge.
- Pulses arriving during SCORE are ignored.
- blink toggles when its counter wraps at BLINK_DIV-1; the counter free-runs from reset.

## Test plan
- SET with no switch active: confirm x4 with rand_digit sequence 3,3,7,1,5 -> target 3,7,1,5. The repeated 3 is rejected, and phase is GUESS after the 4th accepted digit.
- Target 1234, guess 1325 -> score_valid exactly N+1 cycles after the final confirm; res_a = 1, res_b = 2, tries_left 5 -> 4, phase RESULT.
- Guess 1234 against target 1234 -> phase WIN, display 4,A,0,b; a further confirm causes no change.
- MAX_TRIES = 2, two wrong guesses -> tries_left 0, phase LOSE, display = target.
- Three wrong rounds, then hist_pulse x3 in RESULT -> views cycle newest, middle, oldest, then newest again, with matching res_a/res_b each time.
- Back at pos N-1, confirm and back in the same cycle, digit_in = 12, and reset asserted mid-SCORE -> respectively ignored, confirm taken, rejected, and all reset values restored immediately.
